// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship monster logic: state encodings,
// slot numbering and a small popcount helper.
package nexys_starship_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'b001,
    ST_PLAY = 3'b010,
    ST_OVER = 3'b100
  } state_t;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    SLOT_TOP    = 2'd0,
    SLOT_BOTTOM = 2'd1,
    SLOT_LEFT   = 2'd2,
    SLOT_RIGHT  = 2'd3
  } slot_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the spawn
// randomness source.
module nexys_starship_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] lfsr_state
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  assign lfsr_state = lfsr_reg;

endmodule

// File: rtl/nexys_starship_monster_scheduler.sv
// Central monster controller: spawns monsters into free slots, runs per-slot
// attack timers, clears slots on hits and ends the game on timer expiry.
module nexys_starship_monster_scheduler
  import nexys_starship_pkg::*;
#(
  parameter int          SPAWN_MIN        = 8,
  parameter int          SPAWN_RANGE_BITS = 3,
  parameter int          ATTACK_TICKS     = 40,
  parameter int          MAX_ACTIVE       = 3,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        tick,
  input  logic        play_flag,
  input  logic        restart,
  input  logic [3:0]  shoot_hit,
  output logic [3:0]  spawn_pulse,
  output logic [3:0]  monster_active,
  output logic        game_over,
  output logic [15:0] kill_count,
  output logic        q_Init,
  output logic        q_Play,
  output logic        q_Over
);

  localparam int SPAWN_W = $clog2(SPAWN_MIN + (1 << SPAWN_RANGE_BITS)) + 1;
  localparam int ATK_W   = $clog2(ATTACK_TICKS + 1) + 1;

  state_t                state_reg, state_next;
  logic [SPAWN_W-1:0]    spawn_cnt_reg, spawn_cnt_next;
  logic [ATK_W-1:0]      atk_cnt_reg [NUM_SLOTS];
  logic [ATK_W-1:0]      atk_cnt_next [NUM_SLOTS];
  logic [ATK_W-1:0]      atk_dec [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  active_reg, active_next;
  logic [NUM_SLOTS-1:0]  pulse_reg, pulse_next;
  logic [15:0]           kill_reg, kill_next;
  logic [NUM_SLOTS-1:0]  hit_valid, expire;
  logic [NUM_SLOTS:0]    free_slot;
  logic                  can_spawn;
  logic [16:0]           kill_sum;
  logic [SPAWN_W-1:0]    spawn_reload;
  logic [15:0]           lfsr;
  logic                  lfsr_unused;

  nexys_starship_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk        (Clk),
    .Reset      (Reset),
    .lfsr_state (lfsr)
  );

  // Returns {found, one-hot slot}: first free slot scanning upward from start.
  function automatic logic [NUM_SLOTS:0] find_free(input logic [NUM_SLOTS-1:0] act,
                                                   input logic [1:0] start);
    logic [NUM_SLOTS:0] res;
    slot_t              idx;
    res = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      idx = slot_t'(start + 2'(k));
      if (!act[idx]) begin
        res            = '0;
        res[NUM_SLOTS] = 1'b1;
        res[idx]       = 1'b1;
      end
    end
    return res;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign hit_valid[gi] = shoot_hit[gi] & active_reg[gi];
      // A hit in the same cycle outranks an expiring timer on that slot.
      assign expire[gi]    = active_reg[gi] & ~hit_valid[gi] & (atk_cnt_reg[gi] == '0);
      assign atk_dec[gi]   = (atk_cnt_reg[gi] == '0) ? atk_cnt_reg[gi] : atk_cnt_reg[gi] - 1'b1;
    end
  endgenerate

  assign free_slot    = find_free(active_reg, lfsr[1:0]);
  assign can_spawn    = free_slot[NUM_SLOTS] && (int'(popcount4(active_reg)) < MAX_ACTIVE);
  assign kill_sum     = {1'b0, kill_reg} + 17'(popcount4(hit_valid));
  assign spawn_reload = SPAWN_W'(SPAWN_MIN) + SPAWN_W'(lfsr[SPAWN_RANGE_BITS+1:2]);
  assign lfsr_unused  = ^lfsr[15:SPAWN_RANGE_BITS+2];

  always_comb begin
    state_next     = state_reg;
    spawn_cnt_next = spawn_cnt_reg;
    active_next    = active_reg;
    pulse_next     = '0;
    kill_next      = kill_reg;
    for (int i = 0; i < NUM_SLOTS; i++) atk_cnt_next[i] = atk_cnt_reg[i];

    case (state_reg)
      ST_INIT: begin
        active_next = '0;
        kill_next   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) atk_cnt_next[i] = '0;
        if (play_flag) begin
          state_next     = ST_PLAY;
          spawn_cnt_next = SPAWN_W'(SPAWN_MIN);
        end
      end
      ST_PLAY: begin
        active_next = active_reg & ~hit_valid;
        kill_next   = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
        if (tick) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active_reg[i] && !hit_valid[i]) atk_cnt_next[i] = atk_dec[i];
          end
          if (spawn_cnt_reg != '0) begin
            spawn_cnt_next = spawn_cnt_reg - 1'b1;
          end else begin
            if (can_spawn) begin
              pulse_next  = free_slot[NUM_SLOTS-1:0];
              active_next = active_next | free_slot[NUM_SLOTS-1:0];
              for (int i = 0; i < NUM_SLOTS; i++) begin
                if (free_slot[i]) atk_cnt_next[i] = ATK_W'(ATTACK_TICKS);
              end
            end
            spawn_cnt_next = spawn_reload;
          end
          if (|expire) state_next = ST_OVER;
        end
      end
      ST_OVER: begin
        if (restart) begin
          state_next  = ST_INIT;
          active_next = '0;
          kill_next   = '0;
          for (int i = 0; i < NUM_SLOTS; i++) atk_cnt_next[i] = '0;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_INIT;
      spawn_cnt_reg <= '0;
      active_reg    <= '0;
      pulse_reg     <= '0;
      kill_reg      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) atk_cnt_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      spawn_cnt_reg <= spawn_cnt_next;
      active_reg    <= active_next;
      pulse_reg     <= pulse_next;
      kill_reg      <= kill_next;
      for (int i = 0; i < NUM_SLOTS; i++) atk_cnt_reg[i] <= atk_cnt_next[i];
    end
  end

  assign spawn_pulse    = pulse_reg;
  assign monster_active = active_reg;
  assign kill_count     = kill_reg;
  assign q_Init         = state_reg[0];
  assign q_Play         = state_reg[1];
  assign q_Over         = state_reg[2];
  assign game_over      = state_reg[2];

endmodule

// File: tb/tb_nexys_starship_monster_scheduler.sv
// Directed bench for the monster scheduler with a cycle-level reference model
// of the scheduling rules and the spawn LFSR.
module tb_nexys_starship_monster_scheduler;

  localparam int          SPAWN_MIN        = 2;
  localparam int          SPAWN_RANGE_BITS = 2;
  localparam int          ATTACK_TICKS     = 5;
  localparam int          MAX_ACTIVE       = 2;
  localparam logic [15:0] SEED             = 16'hACE1;

  logic        Clk, Reset, tick, play_flag, restart;
  logic [3:0]  shoot_hit, spawn_pulse, monster_active;
  logic        game_over, q_Init, q_Play, q_Over;
  logic [15:0] kill_count;

  nexys_starship_monster_scheduler #(
    .SPAWN_MIN        (SPAWN_MIN),
    .SPAWN_RANGE_BITS (SPAWN_RANGE_BITS),
    .ATTACK_TICKS     (ATTACK_TICKS),
    .MAX_ACTIVE       (MAX_ACTIVE),
    .LFSR_SEED        (SEED)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .tick           (tick),
    .play_flag      (play_flag),
    .restart        (restart),
    .shoot_hit      (shoot_hit),
    .spawn_pulse    (spawn_pulse),
    .monster_active (monster_active),
    .game_over      (game_over),
    .kill_count     (kill_count),
    .q_Init         (q_Init),
    .q_Play         (q_Play),
    .q_Over         (q_Over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state (0=INIT, 1=PLAY, 2=OVER)
  int          m_state;
  logic [3:0]  m_act, m_pulse;
  int          m_atk [4];
  int          m_scnt, m_kill, m_blocked;
  logic        m_last_blocked;
  logic [15:0] m_lfsr, m_lfsr_seen;
  logic        play_lvl;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_act = '0; m_pulse = '0; m_scnt = 0; m_kill = 0;
    for (int i = 0; i < 4; i++) m_atk[i] = 0;
    m_lfsr = SEED;
  endfunction

  function automatic void model_eval();
    logic [3:0] vh, new_act;
    logic       exp_any, found;
    int         idx, s, pc;
    m_lfsr_seen    = m_lfsr;
    m_last_blocked = 1'b0;
    if (Reset) begin
      model_reset();
      return;
    end
    case (m_state)
      0: begin
        m_act = '0; m_kill = 0; m_pulse = '0;
        for (int i = 0; i < 4; i++) m_atk[i] = 0;
        if (play_flag) begin m_state = 1; m_scnt = SPAWN_MIN; end
      end
      1: begin
        m_pulse = '0;
        vh      = shoot_hit & m_act;
        new_act = m_act & ~vh;
        m_kill  = m_kill + $countones(vh);
        if (m_kill > 65535) m_kill = 65535;
        exp_any = 1'b0;
        if (tick) begin
          for (int i = 0; i < 4; i++) begin
            if (m_act[i] && !vh[i]) begin
              if (m_atk[i] > 0) m_atk[i]--; else exp_any = 1'b1;
            end
          end
          if (m_scnt > 0) begin
            m_scnt--;
          end else begin
            pc = $countones(m_act); found = 1'b0; s = 0;
            for (int k = 0; k < 4; k++) begin
              idx = (int'(m_lfsr[1:0]) + k) % 4;
              if (!found && !m_act[idx]) begin found = 1'b1; s = idx; end
            end
            if (found && pc < MAX_ACTIVE) begin
              m_pulse[s] = 1'b1; new_act[s] = 1'b1; m_atk[s] = ATTACK_TICKS;
            end else begin
              m_blocked++; m_last_blocked = 1'b1;
            end
            m_scnt = SPAWN_MIN + int'(m_lfsr[3:2]);
          end
        end
        m_act = new_act;
        if (exp_any) m_state = 2;
      end
      default: begin
        m_pulse = '0;
        if (restart) begin
          m_state = 0; m_act = '0; m_kill = 0;
          for (int i = 0; i < 4; i++) m_atk[i] = 0;
        end
      end
    endcase
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endfunction

  task automatic compare_all(input string ph);
    check_val({ph, "_spawn_pulse"}, spawn_pulse, m_pulse);
    check_val({ph, "_active"}, monster_active, m_act);
    check_val({ph, "_game_over"}, game_over, m_state == 2);
    check_val({ph, "_kill"}, kill_count, 32'(m_kill));
    check_val({ph, "_q_Init"}, q_Init, m_state == 0);
    check_val({ph, "_q_Play"}, q_Play, m_state == 1);
    check_val({ph, "_q_Over"}, q_Over, m_state == 2);
  endtask

  // One clock: drive at a falling edge, model it, check at the next falling edge.
  task automatic step(input logic t, input logic [3:0] h, input logic pf, input logic rs);
    tick = t; shoot_hit = h; play_flag = pf; restart = rs;
    model_eval();
    @(negedge Clk);
    compare_all("cyc");
    tick = 1'b0; shoot_hit = '0; restart = 1'b0;
  endtask

  task automatic do_tick(input logic [3:0] h);
    step(1'b1, h, play_lvl, 1'b0);
    $display("t=%0t tick hit=%b pulse=%b active=%b kill=%0d over=%b",
             $time, h, spawn_pulse, monster_active, kill_count, game_over);
    if (m_last_blocked) check_val("blocked_no_pulse", spawn_pulse, 0);
    repeat (3) step(1'b0, 4'b0000, play_lvl, 1'b0);
  endtask

  function automatic logic [3:0] expiry_hits();
    logic [3:0] h;
    h = '0;
    for (int i = 0; i < 4; i++) if (m_act[i] && m_atk[i] == 0) h[i] = 1'b1;
    return h;
  endfunction

  task automatic start_game();
    play_lvl = 1'b1;
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    check_val("play_entered", q_Play, 1);
  endtask

  task automatic restart_game();
    play_lvl = 1'b0;
    step(1'b0, 4'b0000, 1'b0, 1'b1);
    check_val("restart_q_Init", q_Init, 1);
    check_val("restart_kill_zero", kill_count, 0);
  endtask

  initial begin
    logic [3:0] h, exp_pulse;
    int         s, kill_before, n_exp_hits;
    Reset = 1'b1; tick = 1'b0; play_flag = 1'b0; restart = 1'b0; shoot_hit = '0;
    play_lvl = 1'b0; m_blocked = 0; m_last_blocked = 1'b0; n_exp_hits = 0;
    model_reset();
    m_lfsr_seen = SEED;
    @(negedge Clk);
    compare_all("reset");
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    Reset = 1'b0;

    // First game: first attempt on the third tick, hits on an empty field
    start_game();
    do_tick(4'b0000);
    do_tick(4'b1111);
    check_val("hit_empty_kill", kill_count, 0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    exp_pulse = 4'b0001 << m_lfsr_seen[1:0];
    check_val("first_spawn_slot", spawn_pulse, exp_pulse);
    check_val("first_spawn_onehot", $countones(spawn_pulse), 1);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    check_val("pulse_one_cycle", spawn_pulse, 0);
    step(1'b0, exp_pulse, 1'b1, 1'b0);
    check_val("hit_clears_slot", monster_active & exp_pulse, 0);
    check_val("hit_kill_one", kill_count, 1);
    repeat (2) step(1'b0, 4'b0000, 1'b1, 1'b0);

    // Keep the game alive by hitting each monster on its expiry tick
    for (int n = 0; n < 400; n++) begin
      h = expiry_hits();
      kill_before = m_kill;
      do_tick(h);
      if (h != 4'b0000) begin
        n_exp_hits++;
        check_val("hit_at_expiry_no_over", game_over, 0);
        check_val("hit_at_expiry_kill", kill_count, 32'(kill_before + $countones(h)));
      end
      if (n >= 40 && m_blocked >= 2 && n_exp_hits >= 2) break;
    end
    $display("info: full-occupancy attempts=%0d expiry-tick hits=%0d", m_blocked, n_exp_hits);

    // Stop hitting and let a timer run out
    for (int n = 0; n < 20 && m_state != 2; n++) do_tick(4'b0000);
    check_val("over_reached", game_over, 1);
    repeat (4) step(1'b0, 4'b1111, 1'b0, 1'b0);
    restart_game();
    step(1'b0, 4'b0000, 1'b0, 1'b0);

    // Second game: unhit monster ends the game after its 6th tick
    start_game();
    do_tick(4'b0000);
    do_tick(4'b0000);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    check_val("g2_spawn_onehot", $countones(spawn_pulse), 1);
    s = 0;
    for (int i = 0; i < 4; i++) if (m_pulse[i]) s = i;
    repeat (3) step(1'b0, 4'b0000, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      do_tick(4'b0000);
      check_val("no_over_before_6th", game_over, 0);
    end
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    check_val("over_after_6th", game_over, 1);
    check_val("over_q_Over", q_Over, 1);
    repeat (3) step(1'b0, 4'b0000, 1'b1, 1'b0);
    do_tick(4'b0000);
    check_val("frozen_slot", monster_active[s], 1);
    restart_game();
    step(1'b0, 4'b0000, 1'b0, 1'b0);

    // Third game: reach two live monsters, then reset mid-cycle
    start_game();
    for (int n = 0; n < 200 && $countones(m_act) != 2; n++) do_tick(expiry_hits());
    check_val("two_active", $countones(monster_active), 2);
    #2 Reset = 1'b1;
    #1 model_reset();
    compare_all("async_reset");
    check_val("async_reset_active", monster_active, 0);
    check_val("async_reset_q_Init", q_Init, 1);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    Reset = 1'b0;
    play_lvl = 1'b0;
    repeat (2) step(1'b0, 4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/nexys_starship_monster_scheduler.md
# nexys_starship_monster_scheduler

Central monster controller for Nexys Starship. It decides when and where monsters appear across the four attack slots (top, bottom, left, right). It runs a per-slot attack timer and clears a monster when the player's shot hits it. It raises `game_over` when any attack timer expires. It sits between the game-tick generator and player-input logic on one side, and the four per-direction monster FSMs and the display on the other.

## Interface
Parameters:
- `SPAWN_MIN`, default 8: minimum game ticks between spawn attempts.
- `SPAWN_RANGE_BITS`, default 3: width of the random extra delay added to `SPAWN_MIN`.
- `ATTACK_TICKS`, default 40: attack-timer reload value at spawn.
- `MAX_ACTIVE`, default 3: maximum number of simultaneously active monsters (1..4).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: reset, asynchronous, active-high.
- `tick` in 1: one-cycle game-tick strobe; all timers count only on `tick`.
- `play_flag` in 1: level; starts the game from INIT.
- `restart` in 1: pulse; leaves OVER.
- `shoot_hit` in 4: per-slot pulse, bit 0=top, 1=bottom, 2=left, 3=right.
- `spawn_pulse` out 4: one-cycle spawn command to the slot's monster FSM.
- `monster_active` out 4: per-slot occupied flag.
- `game_over` out 1: high while in OVER.
- `kill_count` out 16: monsters destroyed this game, saturating at 16'hFFFF.
- `q_Init`, `q_Play`, `q_Over` out 1 each: one-hot state.

## Operation
- **States:** INIT=3'b001, PLAY=3'b010, OVER=3'b100. An illegal encoding goes to INIT on the next edge.
- **INIT:**
  - `monster_active`, all attack counters and `kill_count` are held at 0.
  - When `play_flag`=1: go to PLAY and load `spawn_cnt` with `SPAWN_MIN`.
- **PLAY, spawn countdown** (on `tick`):
  - If `spawn_cnt`>0, decrement it.
  - If `spawn_cnt`=0, make a spawn attempt:
    - Start index = `lfsr[1:0]`. Search round-robin upward (mod 4) for the first slot whose `monster_active` was 0 at the start of the cycle.
    - Spawn only if such a slot exists and popcount(`monster_active`) < `MAX_ACTIVE`.
    - Spawn action: set `spawn_pulse[i]`, set `monster_active[i]`, load `atk_cnt[i]` with `ATTACK_TICKS`.
    - Whether or not a spawn occurred, reload `spawn_cnt` with `SPAWN_MIN` + `lfsr[SPAWN_RANGE_BITS+1:2]`.
- **PLAY, attack timers** (on `tick`, per active slot):
  - If `atk_cnt[i]`>0, decrement it.
  - If `atk_cnt[i]`=0, go to OVER.
- **PLAY, hits:** `shoot_hit[i]` with `monster_active[i]`=1 clears the slot and increments `kill_count` (saturating). A hit on an inactive slot is ignored.
- **OVER:** `game_over`=1. Monsters and counters are frozen. `restart`=1 goes to INIT.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Advances every clock in all states. Reset value is `LFSR_SEED`.
- **Simultaneous events:**
  - Hit and expiry on the same slot in the same cycle: the hit wins, with no game over.
  - Hit and spawn in the same cycle: the spawn search uses pre-cycle `monster_active`, so the just-cleared slot is not eligible that cycle.
  - Multiple hits in one cycle: `kill_count` adds the popcount of valid hits.
- **`play_flag` dropping during PLAY:** no effect.

## Timing
- All outputs are registered.
- Reset values:
  - state INIT: `q_Init`=1, `q_Play`=0, `q_Over`=0.
  - `spawn_pulse`=0, `monster_active`=0, `game_over`=0, `kill_count`=0.
  - `spawn_cnt`=0, `atk_cnt`=0, `lfsr`=`LFSR_SEED`.
- Latency:
  - Spawn decision at the `tick` cycle; `spawn_pulse`/`monster_active` visible after the next edge.
  - `spawn_pulse` lasts exactly 1 cycle.
  - Hit clears `monster_active` 1 cycle after `shoot_hit`.
  - `game_over` rises 1 cycle after the expiring `tick`.
- Monster lifetime without a hit: `ATTACK_TICKS`+1 ticks after spawn.
- Spawn interval: `SPAWN_MIN`+1 to `SPAWN_MIN`+2^`SPAWN_RANGE_BITS` ticks.
- Reset mid-game returns everything to reset values immediately (asynchronous).

## Structure
- Shared package `nexys_starship_pkg`:
  - state encodings.
  - `NUM_SLOTS`=4.
  - slot indices TOP=0, BOTTOM=1, LEFT=2, RIGHT=3.
- Sub-module `nexys_starship_lfsr16` (Clk, Reset, seed param, 16-bit state out).
- Round-robin free-slot search is a combinational function inside the scheduler.

## Test plan
Parameters: `SPAWN_MIN`=2, `SPAWN_RANGE_BITS`=2, `ATTACK_TICKS`=5, `MAX_ACTIVE`=2. `tick` every 4 clocks.

1. Reset, then `play_flag`=1 -> PLAY next edge. First spawn attempt on the 3rd tick. Exactly one `spawn_pulse` bit, high for 1 cycle, matching `lfsr[1:0]` (reference-model LFSR).
2. No hits -> `game_over`=1 exactly 1 cycle after the 6th tick following the spawn. State OVER; `monster_active` frozen.
3. Spawn, then `shoot_hit` on that slot -> `monster_active` bit clears next cycle, `kill_count`=1. `shoot_hit`=4'b1111 with no monsters -> `kill_count` unchanged.
4. Two active monsters, `MAX_ACTIVE`=2 -> the next attempt produces no `spawn_pulse` and still reloads `spawn_cnt`.
5. Hit arriving in the same cycle as the expiry tick -> no `game_over`, `kill_count` incremented.
6. `Reset` asserted mid-PLAY with 2 active monsters -> all outputs at reset values immediately. `restart` in OVER -> INIT after 1 cycle, `kill_count`=0.
